regb_fifo_serial_tx: RTL and testbench
======================================

# regb_fifo_serial_tx

Serial transmitter for the read end of the register-based FIFO. It pops one WIDTH-bit word at a time from the FIFO head using the FIFO's `empty_n` / `shift_out` interface. Each word is sent LSB first on a single asynchronous-style serial line, framed by a start bit and a stop bit. It drains the FIFO chain continuously while enabled and the FIFO is non-empty.

## Interface
Parameters:
- WIDTH, 4, data word width; must match the FIFO width.
- DIV, 16, clock cycles per serial bit; DIV >= 2.

Ports:
- clk  input  1  system clock; everything is synchronous to the rising edge.
- res  input  1  reset, asynchronous and active-high.
- fifo_data  input  WIDTH  FIFO head word.
- fifo_empty_n  input  1  FIFO head holds valid data.
- fifo_shift_out  output  1  one-cycle pop request to the FIFO.
- enable  input  1  allows new frames to start.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (compiled in only when the macro is defined)
  - STOP
- Bit counter `bcnt` has width $clog2(DIV). It counts 0..DIV-1 within each serial bit.
- Data index `dcnt` has width $clog2(WIDTH)+1.
- Pop condition: `pop = enable & fifo_empty_n & (state==IDLE | last_stop)`.
  - `last_stop` means state==STOP and bcnt==DIV-1.
  - `fifo_shift_out = pop`. This is a Mealy output and may depend combinationally on the inputs.
  - `fifo_shift_out` is never asserted while fifo_empty_n=0.
- On a pop edge:
  - the shift register loads fifo_data;
  - state goes to START;
  - bcnt clears to 0.
- START: tx=0 for DIV cycles, then DATA with dcnt=0.
- DATA:
  - tx = shreg[0] for DIV cycles per bit.
  - At bcnt==DIV-1: shift right and increment dcnt.
  - After bit WIDTH-1, go to PARITY if compiled in, otherwise STOP.
- STOP: tx=1 for DIV cycles. At last_stop:
  - frame_done=1;
  - next state is START if pop, otherwise IDLE.
- tx is registered and is a function of the state and shift register.
- enable deasserted mid-frame: the current frame completes normally, and no further pop occurs.
- fifo_data is sampled only on the pop edge. Later changes to fifo_data do not affect the frame in flight.

## Timing
- Reset values, applied immediately on res=1 with no clock needed:
  - tx=1, busy=0, fifo_shift_out=0, frame_done=0;
  - state=IDLE, bcnt=0, dcnt=0, shreg=0.
- Pop in cycle T puts the start bit on tx from cycle T+1.
- Frame length is F=(2+WIDTH+P)*DIV cycles, where P=1 with parity and P=0 without.
  - tx carries the frame during cycles T+1..T+F.
  - frame_done is asserted in cycle T+F.
- Back-to-back frames: the next pop occurs in cycle T+F and its start bit begins at T+F+1. There are no idle cycles between frames.
- From IDLE, the pop is in the same cycle that fifo_empty_n & enable first become 1.
- Reset mid-frame:
  - tx goes to 1 asynchronously and the word is lost.
  - After res falls, the block is in IDLE and a pop may happen in the first clock.

## Configuration
- Macro: REGB_TX_PARITY_EN.
- Defined:
  - the PARITY state is present;
  - tx carries the even parity bit (XOR of the WIDTH data bits) for DIV cycles between the last data bit and STOP;
  - P=1.
- Undefined: no PARITY state, DATA goes directly to STOP, and P=0.

## Test plan
All scenarios use WIDTH=4 and DIV=4.

- Reset: assert res mid-operation -> tx=1, busy=0, fifo_shift_out=0, frame_done=0 in the same cycle, with no clock edge required.
- Single word 4'b1011 with enable=1, empty_n=1 for one cycle T -> fifo_shift_out=1 at T only. tx must be:
  - 0 for T+1..T+4;
  - 1, 1, 0, 1 in 4-cycle groups for T+5..T+20;
  - 1 for T+21..T+24.
  - frame_done at T+24 and busy=0 at T+25.
- Back-to-back: words 4'hA then 4'h5 queued -> second pop at T+24, second start bit at T+25, second frame_done at T+48, no tx idle gap.
- Empty FIFO: fifo_empty_n=0 and enable=1 for 50 cycles -> fifo_shift_out never asserted, tx=1, busy=0.
- Enable drop: deassert enable at T+10 while data remains queued -> frame completes with frame_done at T+24, no pop at T+24, IDLE at T+25.
- With REGB_TX_PARITY_EN, word 4'b1011 -> parity bit 1 on T+21..T+24, stop bit on T+25..T+28, frame_done at T+28.

Source files
------------

// File: rtl/regb_fifo_serial_tx.sv
// regb_fifo_serial_tx
// Drains words from the head of the register-based FIFO and sends each one
// LSB first on a serial line, framed by a start bit (0) and a stop bit (1).
// Each serial bit lasts DIV clock cycles. Frames run back to back while
// enable is high and the FIFO holds data.
// Optional feature: define REGB_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module regb_fifo_serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty_n,
  output logic             fifo_shift_out,
  input  logic             enable,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(DIV);
  localparam int DW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef REGB_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
`ifdef REGB_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_last;
  logic last_stop;
  logic pop;

  assign bit_last  = (bcnt_q == BCNT_LAST);
  assign last_stop = (state_q == STOP) && bit_last;
  // Reset gates the pop so the FIFO is never shifted while the block is held.
  assign pop       = ~res & enable & fifo_empty_n & ((state_q == IDLE) | last_stop);

  assign fifo_shift_out = pop;
  assign tx             = tx_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = last_stop;

  // Next-state logic: bit timing, data shifting and frame sequencing.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    shreg_d = shreg_q;
`ifdef REGB_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE) begin
      bcnt_d = bit_last ? '0 : bcnt_q + 1'b1;
    end

    case (state_q)
      START: begin
        if (bit_last) begin
          state_d = DATA;
          dcnt_d  = '0;
        end
      end
      DATA: begin
        if (bit_last) begin
          shreg_d = shreg_q >> 1;
          dcnt_d  = dcnt_q + 1'b1;
          if (dcnt_q == DCNT_LAST) begin
`ifdef REGB_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef REGB_TX_PARITY_EN
      PARITY: begin
        if (bit_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop overrides everything: in IDLE it starts a frame, at the last stop
    // cycle it chains the next frame with no idle gap.
    if (pop) begin
      shreg_d = fifo_data;
      state_d = START;
      bcnt_d  = '0;
`ifdef REGB_TX_PARITY_EN
      parity_d = ^fifo_data;
`endif
    end
  end

  // Serial line level for the upcoming cycle, derived from the next state so
  // that tx is a clean register output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[0];
`ifdef REGB_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with asynchronous reset to an idle, line-high condition.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      dcnt_q   <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
`ifdef REGB_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      dcnt_q   <= dcnt_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef REGB_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_regb_fifo_serial_tx.sv
// Testbench for regb_fifo_serial_tx (WIDTH=4, DIV=4).
// Stimulus pushes words into a FIFO model and the expected serial frame into
// a scoreboard queue; a negedge monitor pops and checks each frame.
module tb_regb_fifo_serial_tx;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;
`ifdef REGB_TX_PARITY_EN
  localparam int FB = 7;
  // Serial bit k of the frame is bit k: {stop, parity, d3, d2, d1, d0, start}
  localparam logic [FB-1:0] PAT_B = 7'b1110110;  // word 4'b1011
  localparam logic [FB-1:0] PAT_A = 7'b1010100;  // word 4'hA
  localparam logic [FB-1:0] PAT_5 = 7'b1001010;  // word 4'h5
  localparam logic [FB-1:0] PAT_C = 7'b1011000;  // word 4'hC
`else
  localparam int FB = 6;
  // Serial bit k of the frame is bit k: {stop, d3, d2, d1, d0, start}
  localparam logic [FB-1:0] PAT_B = 6'b110110;
  localparam logic [FB-1:0] PAT_A = 6'b110100;
  localparam logic [FB-1:0] PAT_5 = 6'b101010;
  localparam logic [FB-1:0] PAT_C = 6'b111000;
`endif
  localparam int F = FB * DIV;

  logic             clk = 1'b0;
  logic             res;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty_n;
  logic             fifo_shift_out;
  logic             enable;
  logic             tx;
  logic             busy;
  logic             frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] fq[$];
  logic [FB-1:0]    exp_q[$];
  int               pop_cycles[$];
  bit               active = 1'b0;
  int               idx = 0;
  logic [FB-1:0]    cur_pat = '0;

  regb_fifo_serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk            (clk),
    .res            (res),
    .fifo_data      (fifo_data),
    .fifo_empty_n   (fifo_empty_n),
    .fifo_shift_out (fifo_shift_out),
    .enable         (enable),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty_n = (fq.size() != 0);
    fifo_data    = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input logic [FB-1:0] pat, input bit expect_tx);
    fq.push_back(w);
    if (expect_tx) exp_q.push_back(pat);
    refresh();
    $display("push word=%h expect_frame=%0d", w, expect_tx);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !active && !busy) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  task automatic wait_pop(input int n0);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (pop_cycles.size() > n0) ok = 1'b1;
    end
    check("wait_pop", ok, 1);
  endtask

  // FIFO model: the head word leaves on the clock edge after a sampled pop.
  initial begin
    bit p;
    forever begin
      @(negedge clk);
      p = fifo_shift_out && !res;
      @(posedge clk);
      #1;
      if (p && fq.size() != 0) void'(fq.pop_front());
      refresh();
    end
  end

  // Monitor: compares every cycle of every frame against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (res) begin
      active = 1'b0;
    end else begin
      check("busy", busy, active);
      if (active) begin
        check("tx_frame", tx, cur_pat[(idx - 1) / DIV]);
        check("frame_done", frame_done, idx == F);
        if (fifo_shift_out) check("pop_at_frame_end", idx, F);
        idx++;
        if (idx > F) active = 1'b0;
      end else begin
        check("tx_idle", tx, 1);
        check("frame_done_idle", frame_done, 0);
      end
      if (fifo_shift_out) begin
        check("pop_not_empty", fifo_empty_n, 1);
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur_pat = exp_q.pop_front();
          active  = 1'b1;
          idx     = 1;
          pop_cycles.push_back(cyc);
          $display("frame start cycle=%0d pattern=%b", cyc, cur_pat);
        end
      end
    end
  end

  initial begin
    int n0;
    int t0;
    int rel;
    res    = 1'b1;
    enable = 1'b0;
    refresh();
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_shift_out", fifo_shift_out, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk);
    #3;
    res = 1'b0;

    // Single word 4'b1011
    @(posedge clk);
    #1;
    enable = 1'b1;
    n0 = pop_cycles.size();
    push_word(4'b1011, PAT_B, 1'b1);
    wait_idle("single_idle");
    check("single_pops", pop_cycles.size() - n0, 1);

    // Back-to-back 4'hA then 4'h5
    n0 = pop_cycles.size();
    push_word(4'hA, PAT_A, 1'b1);
    push_word(4'h5, PAT_5, 1'b1);
    wait_idle("b2b_idle");
    check("b2b_pops", pop_cycles.size() - n0, 2);
    if (pop_cycles.size() - n0 == 2)
      check("b2b_spacing", pop_cycles[n0 + 1] - pop_cycles[n0], F);

    // Empty FIFO with enable high for 50 cycles
    n0 = pop_cycles.size();
    repeat (50) @(posedge clk);
    #1;
    check("empty_no_pop", pop_cycles.size(), n0);

    // Enable drop at T+10 with a second word still queued
    n0 = pop_cycles.size();
    push_word(4'hC, PAT_C, 1'b1);
    push_word(4'h5, PAT_5, 1'b0);
    wait_pop(n0);
    t0 = (pop_cycles.size() > n0) ? pop_cycles[n0] : cyc;
    for (int i = 0; i < 40 && cyc < t0 + 10; i++) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    wait_idle("drop_idle");
    check("drop_pops", pop_cycles.size() - n0, 1);
    check("drop_left_in_fifo", fq.size(), 1);
    fq.delete();
    refresh();

    // Reset mid-frame, then a pop in the first cycle after release
    enable = 1'b1;
    n0 = pop_cycles.size();
    push_word(4'b1011, PAT_B, 1'b1);
    wait_pop(n0);
    repeat (2) @(posedge clk);
    #3;
    res = 1'b1;
    push_word(4'h5, PAT_5, 1'b1);
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_shift_out", fifo_shift_out, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk);
    #3;
    res = 1'b0;
    rel = cyc;
    n0 = pop_cycles.size();
    wait_idle("post_rst_idle");
    check("post_rst_pops", pop_cycles.size() - n0, 1);
    if (pop_cycles.size() > n0)
      check("post_rst_pop_cycle", pop_cycles[n0], rel);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
